// File: rtl/ah_arb_requester_32_if.sv
// ah_arb_requester_32_if: request, grant and index-handoff bundle shared by the requester,
// the arbiter and the downstream consumer.
interface ah_arb_requester_32_if #(
    parameter int N     = 32,
    parameter int IDXW  = 5,
    parameter int HOLDW = 4
);
    logic [N-1:0]     req_pulse;
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [HOLDW-1:0] hold_cycles;
    logic             grant_valid;
    logic [IDXW-1:0]  grant_idx;
    logic             grant_ready;
    logic             busy;
    logic             gnt_err;
    modport slave (
        input  req_pulse, gnt, hold_cycles, grant_ready,
        output req, grant_valid, grant_idx, busy, gnt_err
    );
    modport master (
        output req_pulse, gnt, hold_cycles, grant_ready,
        input  req, grant_valid, grant_idx, busy, gnt_err
    );
endinterface

// File: rtl/ah_arb_requester_32.sv
// ah_arb_requester_32: queues client request strobes for a 32-way arbiter, hands the granted
// index downstream over valid/ready, then withholds all requests for a programmable tenure.
module ah_arb_requester_32 #(
    parameter int N     = 32,
    parameter int IDXW  = 5,
    parameter int HOLDW = 4
) (
    input logic                  clk,
    input logic                  rst,
    ah_arb_requester_32_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OFFER, HOLD} state_t;
    state_t           state, state_nx;
    logic [N-1:0]     pending, clr;
    logic [HOLDW-1:0] cnt, cnt_nx;
    logic [IDXW-1:0]  idx, idx_nx, enc;
    logic             err, err_nx, hit;
    always_comb begin
        enc = '0;
        for (int i = 0; i < N; i++)
            enc = bus.gnt[i] ? (enc | IDXW'(i)) : enc;
    end
    assign hit = $onehot(bus.gnt) && |(bus.gnt & pending);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            cnt     <= '0;
            idx     <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            pending <= (pending & ~clr) | bus.req_pulse;
            cnt     <= cnt_nx;
            idx     <= idx_nx;
            err     <= err_nx;
        end
    end
    // Grants outside IDLE are a lagging arbiter output and are ignored without error.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        clr      = '0;
        err_nx   = err;
        if (state == IDLE) begin
            if (hit) begin
                idx_nx   = enc;
                clr      = bus.gnt;
                state_nx = OFFER;
            end else if (|bus.gnt) begin
                err_nx = 1'b1;
            end
        end else if (state == OFFER) begin
            if (bus.grant_ready) begin
                cnt_nx   = bus.hold_cycles;
                state_nx = (bus.hold_cycles != '0) ? HOLD : IDLE;
            end
        end else begin
            cnt_nx   = cnt - 1'b1;
            state_nx = (cnt == HOLDW'(1)) ? IDLE : HOLD;
        end
    end
    assign bus.req         = (state == IDLE) ? pending : '0;
    assign bus.grant_valid = (state == OFFER);
    assign bus.grant_idx   = idx;
    assign bus.busy        = (state != IDLE);
    assign bus.gnt_err     = err;
endmodule

// File: tb/tb_ah_arb_requester_32.sv
// tb_ah_arb_requester_32: directed and random stimulus against a cycle-count reference model;
// expected grant indices flow through a queue to an independent monitor.
module tb_ah_arb_requester_32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    ah_arb_requester_32_if bus ();
    ah_arb_requester_32 dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    // Reference model: owner is either being offered, or the resource is free from m_free_at on.
    logic [31:0] m_pend;
    bit          m_offer, m_err, m_free;
    int          m_free_at, cyc;
    logic [4:0]  exp_q[$];
    assign m_free = !m_offer && cyc >= m_free_at;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend    <= '0;
            m_offer   <= 1'b0;
            m_err     <= 1'b0;
            m_free_at <= 0;
            cyc       <= 0;
            exp_q.delete();
        end else begin
            logic [31:0] c;
            c = '0;
            if (m_free) begin
                if ($countones(bus.gnt) == 1 && (bus.gnt & m_pend) != 0) begin
                    c = bus.gnt;
                    exp_q.push_back(5'($clog2(bus.gnt)));
                    m_offer <= 1'b1;
                end else if (bus.gnt != 0) begin
                    m_err <= 1'b1;
                end
            end else if (m_offer && bus.grant_ready) begin
                m_offer   <= 1'b0;
                m_free_at <= cyc + 1 + int'(bus.hold_cycles);
            end
            m_pend <= (m_pend & ~c) | bus.req_pulse;
            cyc    <= cyc + 1;
        end
    end
    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction
    always @(negedge clk) begin
        if (!rst) begin
            check("req", bus.req, m_free ? m_pend : 32'h0);
            check("busy", 32'(bus.busy), 32'(!m_free));
            check("grant_valid", 32'(bus.grant_valid), 32'(m_offer));
            check("gnt_err", 32'(bus.gnt_err), 32'(m_err));
            if (bus.grant_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_offer", 32'(bus.grant_idx), 32'hffff_ffff);
                end else begin
                    check("grant_idx", 32'(bus.grant_idx), 32'(exp_q[0]));
                    if (bus.grant_ready) void'(exp_q.pop_front());
                end
            end
        end
    end
    task automatic drive(input logic [31:0] p, input logic [31:0] g, input bit rdy, input logic [3:0] h);
        @(posedge clk);
        #2;
        bus.req_pulse   = p;
        bus.gnt         = g;
        bus.grant_ready = rdy;
        bus.hold_cycles = h;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0, 1'b1, 4'd0);
    endtask
    task automatic reset_now();
        bus.req_pulse = '0;
        bus.gnt       = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_grant_valid", 32'(bus.grant_valid), 32'h0);
        check("rst_req", bus.req, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask
    initial begin
        bus.req_pulse   = '0;
        bus.gnt         = '0;
        bus.grant_ready = 1'b0;
        bus.hold_cycles = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        check("reset_req", bus.req, 32'h0);
        check("reset_valid", 32'(bus.grant_valid), 32'h0);
        check("reset_idx", 32'(bus.grant_idx), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_err", 32'(bus.gnt_err), 32'h0);
        // basic grant, zero tenure
        drive(32'h20, '0, 1'b1, 4'd0);
        drive('0, '0, 1'b1, 4'd0);
        check("basic_req5", bus.req, 32'h20);
        drive('0, 32'h20, 1'b1, 4'd0);
        drive('0, '0, 1'b1, 4'd0);
        check("basic_valid", 32'(bus.grant_valid), 32'h1);
        check("basic_idx", 32'(bus.grant_idx), 32'd5);
        check("basic_req0", bus.req, 32'h0);
        drive('0, '0, 1'b1, 4'd0);
        check("basic_idle", 32'(bus.busy), 32'h0);
        // back-pressure, tenure 4, lagging grant during tenure
        drive(32'h200, '0, 1'b0, 4'd4);
        drive('0, 32'h200, 1'b0, 4'd4);
        repeat (3) drive('0, '0, 1'b0, 4'd4);
        drive('0, '0, 1'b1, 4'd4);
        drive('0, 32'h1000, 1'b0, 4'd9);
        check("lag_busy", 32'(bus.busy), 32'h1);
        drive('0, '0, 1'b0, 4'd1);
        check("lag_err", 32'(bus.gnt_err), 32'h0);
        idle(5);
        // multiple pending; re-request of bit 31 while it is granted
        drive(32'h8000_0001, '0, 1'b1, 4'd0);
        drive(32'h8000_0000, 32'h8000_0000, 1'b1, 4'd0);
        drive('0, '0, 1'b1, 4'd0);
        check("multi_idx", 32'(bus.grant_idx), 32'd31);
        idle(2);
        check("multi_pend", bus.req, 32'h8000_0001);
        // protocol errors
        drive('0, 32'h3, 1'b1, 4'd0);
        drive('0, '0, 1'b1, 4'd0);
        check("err_multi", 32'(bus.gnt_err), 32'h1);
        check("err_multi_idle", 32'(bus.busy), 32'h0);
        drive('0, 32'h80, 1'b1, 4'd0);
        idle(3);
        check("err_sticky", 32'(bus.gnt_err), 32'h1);
        // reset while offering
        drive(32'h8, '0, 1'b0, 4'd0);
        drive('0, 32'h8, 1'b0, 4'd0);
        drive('0, '0, 1'b0, 4'd0);
        check("pre_rst_valid", 32'(bus.grant_valid), 32'h1);
        reset_now();
        check("post_rst_err", 32'(bus.gnt_err), 32'h0);
        idle(2);
        // random traffic
        for (int k = 0; k < 600; k++) begin
            logic [31:0] p, g;
            int r, b;
            p = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
            if ($urandom_range(0, 9) == 0) p = p | $urandom;
            r = $urandom_range(0, 9);
            g = '0;
            if (r < 5 && m_pend != 0) begin
                do b = $urandom_range(0, 31); while (!m_pend[b]);
                g = 32'h1 << b;
            end else if (r == 5) begin
                g = 32'h1 << $urandom_range(0, 31);
            end else if (r == 6) begin
                g = $urandom;
            end
            drive(p, g, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
            if (k % 150 == 149) reset_now();
        end
        idle(20);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ah_arb_requester_32.md
# ah_arb_requester_32

Requester-side companion to the 32-way round-robin arbiter. It collects per-client request strobes into pending bits and presents them as the arbiter's `req` vector. It accepts the arbiter's one-hot `gnt`, encodes it into an index, and hands that index downstream over a valid/ready handshake. It then holds off all requests for a programmable tenure so the granted client owns the shared resource.

## Interface
- `N`, 32: number of clients; fixed to match the 32-way arbiter.
- `IDXW`, 5: grant index width, log2(N).
- `HOLDW`, 4: width of the tenure count.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_pulse` in N: one-cycle request strobe per client; may carry several bits per cycle.
- `req` out N: request vector to the arbiter.
- `gnt` in N: one-hot grant from the arbiter; only single-cycle pulses are expected.
- `hold_cycles` in HOLDW: tenure length in cycles; sampled on handshake.
- `grant_valid` out 1: granted index is available.
- `grant_idx` out IDXW: binary index of the granted client.
- `grant_ready` in 1: downstream accepts the index.
- `busy` out 1: high when the FSM is not in IDLE.
- `gnt_err` out 1: sticky protocol-error flag; cleared only by `rst`.

## Operation
- `pending[N]` register:
  - Bit i sets on `req_pulse[i]`.
  - Bit i clears when a grant to i is accepted in IDLE.
  - If set and clear hit the same bit in the same cycle, the set wins (the client is re-queued).
- `req = pending` when state is IDLE, otherwise 0. `req` is combinational from registers.
- FSM states: IDLE, OFFER, HOLD.
  - **IDLE:** if `gnt` is one-hot and `gnt & pending` is nonzero:
    - latch `grant_idx = encode(gnt)`,
    - clear that pending bit,
    - go to OFFER.
  - **IDLE, error cases:**
    - `gnt` has 2 or more bits set → set `gnt_err`; ignore the grant; stay IDLE.
    - `gnt` is one-hot but its bit is not pending → set `gnt_err`; ignore; stay IDLE.
    - `gnt` = 0 → stay IDLE.
  - **OFFER:** `grant_valid=1`, `grant_idx` held stable.
    - On `grant_ready`: load `cnt = hold_cycles`.
    - Go to HOLD if `hold_cycles != 0`, else go to IDLE.
  - **HOLD:** `cnt` decrements every cycle. When `cnt == 1`, go to IDLE next cycle.
- `gnt` is ignored (no error) in OFFER and HOLD, because the arbiter's registered grant may lag by one cycle.
- `grant_idx` encoding covers 0..31; index 31 encodes as 5'd31, with no wrap.

## Timing
- Reset values:
  - `pending = 0`, state IDLE, `cnt = 0`.
  - `req = 0`, `grant_valid = 0`, `grant_idx = 0`, `busy = 0`, `gnt_err = 0`.
- Latency:
  - `req_pulse` at cycle t → `req` bit high at t+1, if IDLE.
  - `gnt` sampled at t → `grant_valid` and `busy` high at t+1, and `req` drops to 0 at t+1.
- Handshake:
  - `grant_valid` stays high until the cycle in which `grant_ready` is 1.
  - It drops the next cycle.
  - `grant_idx` is stable throughout.
- Tenure:
  - With `hold_cycles = H > 0`, `req` reasserts H+1 cycles after the handshake cycle.
  - With `H = 0`, `req` reasserts 1 cycle after the handshake.
- Reset mid-operation: asserting `rst` in any state immediately drops `grant_valid`, `req` and `busy`. All pending requests are lost.
- `hold_cycles` changing during HOLD has no effect; it is sampled only at the handshake.

## Test plan
- **Basic grant:** `req_pulse[5]` at t0; `gnt = 1<<5` at t2; `grant_ready = 1`; `hold_cycles = 0` → `req[5]` high at t1, `grant_valid`/`grant_idx = 5` at t3, `pending[5] = 0`, `req = 0` at t3, IDLE at t4.
- **Back-pressure and tenure:**
  - `grant_ready` held low 3 cycles after OFFER, then high; `hold_cycles = 4`.
  - Required: `grant_valid` high for 4 cycles with `idx` stable; `req` is 0 until 5 cycles after the handshake; `busy` mirrors this.
- **Multiple pending plus re-request:**
  - `req_pulse = 0x8000_0001`; grant bit 31; `req_pulse[31]` again in the same cycle the grant is taken.
  - Required: `grant_idx = 31`; `pending` ends as `0x8000_0001` (set wins).
- **Errors:**
  - `gnt = 0x0000_0003` in IDLE → `gnt_err = 1`, state stays IDLE, `pending` unchanged.
  - `gnt = 1<<7` with `pending[7] = 0` → `gnt_err = 1`, no offer.
  - `gnt_err` stays high until `rst`.
- **Ignored lagging grant and reset:**
  - `gnt` pulse during HOLD → no state change, `gnt_err = 0`.
  - `rst` asserted in OFFER → `grant_valid = 0`, `pending = 0`, `req = 0` immediately.
